// File: rtl/passcode_ctrl_pkg.sv
// Shared types and constants for the keypad passcode entry controller.
package passcode_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT} state_t;

    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hF;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int MS_DIV       = DEF_CLK_FREQ / 1000;

    // Clock cycles per millisecond tick for an arbitrary clock frequency.
    function automatic int ms_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

endpackage

// File: rtl/passcode_entry_ctrl_if.sv
// Keypad-in / status-out bundle between the keypad scanner side and the entry controller.
interface passcode_entry_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] password;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        unlock;
    logic        fail_flag;
    logic        locked_out;
    logic [1:0]  attempts_left;

    modport master (
        output key_valid, key_code, password,
        input  entry_digits, digit_count, unlock, fail_flag, locked_out, attempts_left
    );

    modport slave (
        input  key_valid, key_code, password,
        output entry_digits, digit_count, unlock, fail_flag, locked_out, attempts_left
    );
endinterface

// File: rtl/ms_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, phase fixed by reset release.
module ms_tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/passcode_entry_ctrl.sv
// Keypad passcode sequencer: digit buffer, check, attempt/lockout and ms timers.
// Optional build macro ENTRY_MASK_EN hides entered digits as 0xE on the display output.
module passcode_entry_ctrl
    import passcode_ctrl_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DIGITS       = 4,
    parameter int MAX_ATTEMPTS = 3,
    parameter int TIMEOUT_MS   = 5000,
    parameter int OPEN_MS      = 3000,
    parameter int FAIL_MS      = 1000,
    parameter int LOCKOUT_MS   = 10000
) (
    input logic                  clk,
    input logic                  rst_n,
    passcode_entry_ctrl_if.slave bus
);
    localparam logic [2:0] FULL    = 3'(DIGITS);
    localparam logic [1:0] ATT_MAX = 2'(MAX_ATTEMPTS);

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  att_q, att_d;
    logic [15:0] timer_q, lim;
    logic [15:0] disp_q, disp_d;
    logic        unlock_q, fail_q, lock_q;
    logic        tick, expire, key_restart, is_digit, is_clear, is_enter;

    ms_tick_gen #(.DIV(ms_div(CLK_FREQ))) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

    assign is_digit = bus.key_valid && (bus.key_code <= 4'h9);
    assign is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign is_enter = bus.key_valid && (bus.key_code == KEY_ENTER);

    always_comb begin
        lim = '1;
        case (state_q)
            ENTRY:   lim = 16'(TIMEOUT_MS);
            OPEN:    lim = 16'(OPEN_MS);
            FAIL:    lim = 16'(FAIL_MS);
            LOCKOUT: lim = 16'(LOCKOUT_MS);
            default: lim = '1;
        endcase
    end

    // Expiry lands on the lim-th tick after the last timer restart.
    assign expire = tick && (timer_q >= lim - 16'd1);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        att_d       = att_q;
        key_restart = 1'b0;
        case (state_q)
            IDLE: if (is_digit) begin
                buf_d   = {buf_q[11:0], bus.key_code};
                cnt_d   = 3'd1;
                state_d = ENTRY;
            end
            ENTRY: begin
                // Accepted keys take priority over a coincident timeout.
                if (is_digit && cnt_q < FULL) begin
                    buf_d       = {buf_q[11:0], bus.key_code};
                    cnt_d       = cnt_q + 3'd1;
                    key_restart = 1'b1;
                end else if (is_clear || (!is_enter && expire)) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (is_enter) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                buf_d = '0;
                cnt_d = '0;
                if (cnt_q == FULL && buf_q == bus.password) begin
                    att_d   = ATT_MAX;
                    state_d = OPEN;
                end else if (att_q <= 2'd1) begin
                    att_d   = '0;
                    state_d = LOCKOUT;
                end else begin
                    att_d   = att_q - 2'd1;
                    state_d = FAIL;
                end
            end
            OPEN:    if (expire || is_clear || is_enter) state_d = IDLE;
            FAIL:    if (expire) state_d = IDLE;
            LOCKOUT: if (expire) begin
                att_d   = ATT_MAX;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_d = buf_d;
`ifdef ENTRY_MASK_EN
        for (int i = 0; i < 4; i++)
            disp_d[i*4 +: 4] = (3'(i) < cnt_d) ? 4'hE : 4'h0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            att_q    <= ATT_MAX;
            timer_q  <= '0;
            disp_q   <= '0;
            unlock_q <= 1'b0;
            fail_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            att_q    <= att_d;
            disp_q   <= disp_d;
            unlock_q <= (state_d == OPEN);
            fail_q   <= (state_d == FAIL);
            lock_q   <= (state_d == LOCKOUT);
            if (state_d != state_q || key_restart) timer_q <= '0;
            else if (tick && timer_q != '1)        timer_q <= timer_q + 16'd1;
        end
    end

    assign bus.entry_digits  = disp_q;
    assign bus.digit_count   = cnt_q;
    assign bus.unlock        = unlock_q;
    assign bus.fail_flag     = fail_q;
    assign bus.locked_out    = lock_q;
    assign bus.attempts_left = att_q;
endmodule

// File: tb/tb_passcode_entry_ctrl.sv
// Directed scoreboard bench for passcode_entry_ctrl (10 clocks per ms tick, short ms limits).
module tb_passcode_entry_ctrl;
    localparam int CLK_FREQ = 10_000;
    localparam int DIV      = 10;
    localparam int T_MS     = 20;
    localparam int O_MS     = 8;
    localparam int F_MS     = 5;
    localparam int L_MS     = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_edge = 0;
    int   e_state = 0;
    logic [1:0] att_e = 2'd3;

    passcode_entry_ctrl_if bus ();

    passcode_entry_ctrl #(
        .CLK_FREQ(CLK_FREQ), .DIGITS(4), .MAX_ATTEMPTS(3), .TIMEOUT_MS(T_MS),
        .OPEN_MS(O_MS), .FAIL_MS(F_MS), .LOCKOUT_MS(L_MS)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Edges since reset release; the ms tick is sampled on every DIV-th edge.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [15:0] ent;
        logic [2:0]  cnt;
        logic        u, f, l;
        logic [1:0]  att;
    } exp_t;
    exp_t sb[$];

    function automatic logic [15:0] disp(input logic [15:0] b, input logic [2:0] c);
        logic [15:0] r;
        r = b;
`ifdef ENTRY_MASK_EN
        r = '0;
        for (int i = 0; i < 4; i++) if (i < int'(c)) r[i*4 +: 4] = 4'hE;
`endif
        return r;
    endfunction

    // Edge on which a timer restarted at edge 'start' expires after 'ms' ticks.
    function automatic int exp_edge(input int start, input int ms);
        return ((start / DIV) + 1) * DIV + DIV * (ms - 1);
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic [15:0] b, input logic [2:0] c,
                            input logic u, input logic f, input logic l);
        exp_t e;
        e.tag = tag; e.ent = disp(b, c); e.cnt = c; e.u = u; e.f = f; e.l = l; e.att = att_e;
        sb.push_back(e);
    endtask

    task automatic check_o();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "entry",  bus.entry_digits, e.ent);
        chk(e.tag, "count",  16'(bus.digit_count), 16'(e.cnt));
        chk(e.tag, "unlock", 16'(bus.unlock), 16'(e.u));
        chk(e.tag, "fail",   16'(bus.fail_flag), 16'(e.f));
        chk(e.tag, "lock",   16'(bus.locked_out), 16'(e.l));
        chk(e.tag, "att",    16'(bus.attempts_left), 16'(e.att));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        last_edge     = cyc + 1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic enter(input logic [15:0] code, input int n);
        logic [15:0] b;
        logic [3:0]  k;
        b = '0;
        for (int i = 0; i < n; i++) begin
            k = code[15 - 4*i -: 4];
            b = {b[11:0], k};
            expect_o("digit", b, 3'(i + 1), 0, 0, 0);
            press(k);
            check_o();
        end
    endtask

    task automatic enter_check(input logic [15:0] code, input int n, input int outcome);
        logic [15:0] b;
        enter(code, n);
        b = code >> (4 * (4 - n));
        expect_o("check", b, 3'(n), 0, 0, 0);
        press(4'hF);
        check_o();
        e_state = cyc + 1;
        if (outcome == 0) att_e = 2'd3;
        else              att_e = att_e - 2'd1;
        expect_o("result", 16'h0, 3'd0, outcome == 0, outcome == 1, outcome == 2);
        step();
        check_o();
    endtask

    task automatic hold_state(input int ms, input logic u, input logic f, input logic l);
        int e;
        e = exp_edge(e_state, ms);
        expect_o("hold", 16'h0, 3'd0, u, f, l);
        wait_edge(e - 1);
        check_o();
        if (l) att_e = 2'd3;
        expect_o("expired", 16'h0, 3'd0, 0, 0, 0);
        wait_edge(e);
        check_o();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.password  = 16'h1234;
        repeat (3) step();
        expect_o("reset", 16'h0, 3'd0, 0, 0, 0);
        check_o();
        rst_n = 1'b1;
        step();

        // correct code, unlock, relock on timer
        enter_check(16'h1234, 4, 0);
        hold_state(O_MS, 1, 0, 0);

        // clear mid-entry, then ENTER in IDLE is ignored
        enter(16'h1200, 2);
        expect_o("clear", 16'h0, 3'd0, 0, 0, 0); press(4'hC); check_o();
        expect_o("idle_f", 16'h0, 3'd0, 0, 0, 0); press(4'hF); check_o();
        expect_o("idle_f2", 16'h0, 3'd0, 0, 0, 0); step(); check_o();
        expect_o("idle_dig", 16'h5, 3'd1, 0, 0, 0); press(4'h5); check_o();
        expect_o("clear2", 16'h0, 3'd0, 0, 0, 0); press(4'hC); check_o();

        // fifth digit ignored, digit in OPEN ignored, CLEAR relocks
        enter(16'h1234, 4);
        expect_o("fifth", 16'h1234, 3'd4, 0, 0, 0); press(4'h9); check_o();
        expect_o("check5", 16'h1234, 3'd4, 0, 0, 0); press(4'hF); check_o();
        expect_o("open5", 16'h0, 3'd0, 1, 0, 0); step(); check_o();
        expect_o("open_dig", 16'h0, 3'd0, 1, 0, 0); press(4'h7); check_o();
        expect_o("open_clr", 16'h0, 3'd0, 0, 0, 0); press(4'hC); check_o();

        // short entry fails; a later password change is honoured at CHECK and resets attempts
        enter_check(16'h1230, 3, 1);
        hold_state(F_MS, 0, 1, 0);
        enter(16'h5678, 4);
        bus.password = 16'h5678;
        expect_o("pw_chk", 16'h5678, 3'd4, 0, 0, 0); press(4'hF); check_o();
        att_e = 2'd3;
        expect_o("pw_open", 16'h0, 3'd0, 1, 0, 0); step(); check_o();
        expect_o("pw_relock", 16'h0, 3'd0, 0, 0, 0); press(4'hF); check_o();
        bus.password = 16'h1234;

        // three wrong codes -> fail, fail, lockout; keys ignored in lockout
        enter_check(16'h1235, 4, 1);
        hold_state(F_MS, 0, 1, 0);
        enter_check(16'h1235, 4, 1);
        hold_state(F_MS, 0, 1, 0);
        enter_check(16'h1235, 4, 2);
        expect_o("lk_dig", 16'h0, 3'd0, 0, 0, 1); press(4'h1); check_o();
        expect_o("lk_ent", 16'h0, 3'd0, 0, 0, 1); press(4'hF); check_o();
        hold_state(L_MS, 0, 0, 1);

        // inactivity timeout, then a key landing exactly on the expiry edge
        enter(16'h1200, 2);
        e = exp_edge(last_edge, T_MS);
        expect_o("to_pre", 16'h12, 3'd2, 0, 0, 0); wait_edge(e - 1); check_o();
        expect_o("to_clr", 16'h0, 3'd0, 0, 0, 0); wait_edge(e); check_o();
        enter(16'h1200, 2);
        e = exp_edge(last_edge, T_MS);
        wait_edge(e - 1);
        expect_o("to_key", 16'h123, 3'd3, 0, 0, 0); press(4'h3); check_o();
        e = exp_edge(last_edge, T_MS);
        expect_o("to_pre2", 16'h123, 3'd3, 0, 0, 0); wait_edge(e - 1); check_o();
        expect_o("to_clr2", 16'h0, 3'd0, 0, 0, 0); wait_edge(e); check_o();

        // asynchronous reset mid-lockout and mid-entry
        enter_check(16'h1111, 4, 1);
        hold_state(F_MS, 0, 1, 0);
        enter_check(16'h1111, 4, 1);
        hold_state(F_MS, 0, 1, 0);
        enter_check(16'h1111, 4, 2);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        att_e = 2'd3;
        expect_o("rst_lk", 16'h0, 3'd0, 0, 0, 0); check_o();
        step(); rst_n = 1'b1; step();
        enter(16'h1200, 2);
        rst_n = 1'b0;
        #1;
        expect_o("rst_en", 16'h0, 3'd0, 0, 0, 0); check_o();
        step(); rst_n = 1'b1; step();
        enter_check(16'h1234, 4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
